ps2_scancode_ctl: RTL and testbench
===================================

# ps2_scancode_ctl

Sequencer between the PS/2 keyboard byte receiver and the CPU/peripheral bus. It consumes the receiver's byte strobe, decodes Set-2 prefix sequences (E0 extended, F0 break, E1 Pause) and separates device status bytes from key codes. Decoded key events go into a FIFO with a valid/ready output handshake. Sits directly downstream of the receiver's `enable_out`/`data_out`, in the same clock domain.

## Interface
- `FIFO_DEPTH`, default 8: event FIFO entries; power of 2, ≥ 2.
- `TIMEOUT_CYCLES`, default 100000: clk cycles allowed between bytes of one multi-byte sequence.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sync_reset`  in  1  synchronous clear; priority over all other inputs.
- `enable_in`  in  1  one-cycle strobe, byte valid on `data_in`.
- `data_in`  in  8  received byte.
- `event_valid`  out  1  FIFO non-empty.
- `event_code`  out  8  head entry key code.
- `event_extended`  out  1  head entry had E0 prefix (or is Pause).
- `event_break`  out  1  head entry is a key release.
- `event_ready`  in  1  consumer accepts head when `event_valid`=1.
- `status_valid`  out  1  one-cycle pulse, device status byte received.
- `status_code`  out  8  status byte, held until next status.
- `error_pulse`  out  1  one-cycle pulse on protocol error or timeout.
- `overflow`  out  1  sticky; an event was dropped because the FIFO was full.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current occupancy.

## Operation
- Status bytes are 00, AA, EE, FA, FC, FE, FF. They are recognised in S_IDLE only. Each one produces `status_valid` and updates `status_code`; no event is generated.
- FSM states: S_IDLE, S_E0, S_F0, S_E0F0, S_PAUSE. Transitions occur only on `enable_in`=1, except for timeout.
- S_IDLE:
  - E0 → S_E0.
  - F0 → S_F0.
  - E1 → S_PAUSE, pause_cnt=0.
  - Status byte → pulse, stay in S_IDLE.
  - Any other byte → push {ext=0, brk=0, code}.
- S_E0:
  - F0 → S_E0F0.
  - 12 → discard (fake shift), go to S_IDLE.
  - E0, E1 → `error_pulse`, go to S_IDLE.
  - Any other byte → push {1, 0, code}, go to S_IDLE.
- S_F0:
  - E0, E1, F0 → `error_pulse`, go to S_IDLE.
  - Any other byte → push {0, 1, code}, go to S_IDLE.
- S_E0F0:
  - 12 → discard, go to S_IDLE.
  - E0, E1, F0 → `error_pulse`, go to S_IDLE.
  - Any other byte → push {1, 1, code}, go to S_IDLE.
- S_PAUSE: absorbs the next 7 bytes of any value (3-bit counter). On the 7th byte, push {1, 0, E1} and go to S_IDLE. No break event is ever produced for Pause.
- Timeout:
  - Cycle counter, width $clog2(TIMEOUT_CYCLES+1), cleared on every `enable_in` and while in S_IDLE.
  - In any other state it increments each cycle.
  - When it reaches TIMEOUT_CYCLES: `error_pulse`, FSM → S_IDLE, counter cleared.
  - If `enable_in` arrives in the same cycle, the byte takes priority and the timeout does not fire.
- FIFO:
  - 10-bit entries {ext, brk, code}, first-word-fall-through.
  - Pop when `event_valid` & `event_ready`.
  - Push when full: event dropped, `overflow` set. Exception: a pop in the same cycle makes room, so both proceed, no drop.
  - Push and pop together when not full: `fifo_count` unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - `event_code`/`event_extended`/`event_break` forced to 0 while `event_valid`=0.
- `sync_reset`: FSM → S_IDLE, FIFO emptied, `overflow`/counters/pulses cleared, `status_code` → 0. Any concurrent byte is ignored.

## Timing
- Reset values (`reset_n` low, or after `sync_reset`): all outputs 0.
- `reset_n` asserted mid-sequence: FSM returns to S_IDLE and the partial sequence is lost.
- Byte sampled at edge N (`enable_in`=1):
  - FSM state, FIFO write, `status_valid`, `error_pulse` and `overflow` all update at edge N.
  - The pulses are high for cycle N+1 only.
  - `event_valid` is high from cycle N+1 (latency 1 cycle).
- Pop at edge M: the next entry is presented in cycle M+1, or `event_valid`=0 if the FIFO is now empty.
- Back-to-back `enable_in` on consecutive cycles must be handled, although the receiver never produces them.
- Throughput with `event_ready` held high: 1 event/cycle.

## Test plan
- Bytes 1C, then F0 1C → events {0,0,1C} then {0,1,1C}; `fifo_count` peaks at 2 with `event_ready`=0.
- E0 75, E0 F0 75, E0 12 E0 7C, E0 F0 7C E0 F0 12 → exactly {1,0,75}, {1,1,75}, {1,0,7C}, {1,1,7C}, in order.
- E1 14 77 E1 F0 14 F0 77 → single event {1,0,E1}; `error_pulse` stays 0.
- FIFO_DEPTH=8, `event_ready`=0, 9 make codes 01..09 → `fifo_count`=8, `overflow`=1 after the 9th, 09 dropped. Then `event_ready`=1 → 01..08 popped in order, one per cycle. Repeat the full case with a pop coincident with a push → no drop.
- TIMEOUT_CYCLES=16: E0, then idle 16 cycles → `error_pulse` exactly once. Next byte 1C → {0,0,1C}, i.e. not extended.
- AA → `status_valid` 1 cycle, `status_code`=AA, no event. F0 E0 → `error_pulse`. `reset_n` low during S_E0F0 → all outputs 0; a following 1C → {0,0,1C}.

Source files
------------

// File: rtl/ps2_scancode_ctl.sv
// Purpose: decodes PS/2 Set-2 byte stream (E0/F0/E1 prefixes, status bytes) into key events held in a FWFT FIFO.
// Latency: byte sampled at edge N -> event_valid / status_valid / error_pulse visible from cycle N+1.
// Backpressure: event_valid/event_ready on the FIFO head; a push into a full FIFO with no pop is dropped and flags overflow.
// Ports: clk, reset_n (async low), sync_reset; enable_in/data_in byte strobe in;
//        event_valid/event_code/event_extended/event_break/event_ready key events out;
//        status_valid/status_code device status; error_pulse, overflow, fifo_count diagnostics.
module ps2_scancode_ctl #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          sync_reset,
  input  logic                          enable_in,
  input  logic [7:0]                    data_in,
  output logic                          event_valid,
  output logic [7:0]                    event_code,
  output logic                          event_extended,
  output logic                          event_break,
  input  logic                          event_ready,
  output logic                          status_valid,
  output logic [7:0]                    status_code,
  output logic                          error_pulse,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_C   = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_E0, S_F0, S_E0F0, S_PAUSE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      pause_cnt_q, pause_cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            status_valid_q, status_valid_d;
  logic [7:0]      status_code_q, status_code_d;
  logic            error_q, error_d;
  logic            overflow_q, overflow_d;
  logic [9:0]      mem_q [FIFO_DEPTH];

  logic            push_req, status_hit, proto_err, tmo_hit;
  logic [9:0]      push_dat, head_dat;
  logic            pop, full, do_push, drop;
  logic            is_status, is_prefix;

  assign is_status = data_in inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  assign is_prefix = data_in inside {8'hE0, 8'hE1, 8'hF0};

  // A byte arriving in the expiry cycle wins over the timeout.
  assign tmo_hit = (state_q != S_IDLE) && !enable_in && (tmo_q == TMO_C);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      pause_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pause_cnt_q <= pause_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    pause_cnt_d = pause_cnt_q;
    if (sync_reset) begin
      state_d     = S_IDLE;
      pause_cnt_d = '0;
    end else if (enable_in) begin
      case (state_q)
        S_IDLE: begin
          if (data_in == 8'hE0)      state_d = S_E0;
          else if (data_in == 8'hF0) state_d = S_F0;
          else if (data_in == 8'hE1) begin
            state_d     = S_PAUSE;
            pause_cnt_d = '0;
          end
        end
        S_E0:    state_d = (data_in == 8'hF0) ? S_E0F0 : S_IDLE;
        S_F0:    state_d = S_IDLE;
        S_E0F0:  state_d = S_IDLE;
        S_PAUSE: begin
          // Pause is E1 followed by 7 fixed bytes; contents are not inspected.
          if (pause_cnt_q == 3'd6) state_d = S_IDLE;
          else                     pause_cnt_d = pause_cnt_q + 3'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (tmo_hit) begin
      state_d = S_IDLE;
    end
  end

  // Decoded actions (Mealy outputs on the accepted byte)
  always_comb begin
    push_req   = 1'b0;
    push_dat   = '0;
    status_hit = 1'b0;
    proto_err  = 1'b0;
    if (!sync_reset && enable_in) begin
      case (state_q)
        S_IDLE: begin
          if (!is_prefix) begin
            if (is_status) status_hit = 1'b1;
            else begin
              push_req = 1'b1;
              push_dat = {2'b00, data_in};
            end
          end
        end
        S_E0: begin
          // E0 12 is the fake-shift the keyboard emits around extended keys.
          if (data_in == 8'hE0 || data_in == 8'hE1) proto_err = 1'b1;
          else if (data_in != 8'hF0 && data_in != 8'h12) begin
            push_req = 1'b1;
            push_dat = {2'b10, data_in};
          end
        end
        S_F0: begin
          if (is_prefix) proto_err = 1'b1;
          else begin
            push_req = 1'b1;
            push_dat = {2'b01, data_in};
          end
        end
        S_E0F0: begin
          if (is_prefix) proto_err = 1'b1;
          else if (data_in != 8'h12) begin
            push_req = 1'b1;
            push_dat = {2'b11, data_in};
          end
        end
        S_PAUSE: begin
          if (pause_cnt_q == 3'd6) begin
            push_req = 1'b1;
            push_dat = {2'b10, 8'hE1};
          end
        end
        default: ;
      endcase
    end
  end

  // Inter-byte timeout counter and FIFO bookkeeping
  assign pop     = event_valid & event_ready;
  assign full    = (count_q == DEPTH_C);
  assign do_push = push_req & (~full | pop);
  assign drop    = push_req & full & ~pop;

  always_comb begin
    tmo_d          = tmo_q + 1'b1;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    status_valid_d = status_hit;
    status_code_d  = status_hit ? data_in : status_code_q;
    error_d        = proto_err | tmo_hit;
    overflow_d     = overflow_q | drop;
    if (enable_in || state_q == S_IDLE || tmo_hit) tmo_d = '0;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !pop)      count_d = count_q + 1'b1;
    else if (!do_push && pop) count_d = count_q - 1'b1;
    if (sync_reset) begin
      tmo_d          = '0;
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      count_d        = '0;
      status_valid_d = 1'b0;
      status_code_d  = '0;
      error_d        = 1'b0;
      overflow_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      status_valid_q <= 1'b0;
      status_code_q  <= '0;
      error_q        <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      tmo_q          <= tmo_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      status_valid_q <= status_valid_d;
      status_code_q  <= status_code_d;
      error_q        <= error_d;
      overflow_q     <= overflow_d;
    end
  end

  // Storage needs no reset: only entries below count_q are ever presented.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

  assign head_dat       = mem_q[rd_ptr_q];
  assign event_valid    = (count_q != '0);
  assign event_code     = event_valid ? head_dat[7:0] : 8'h00;
  assign event_break    = event_valid & head_dat[8];
  assign event_extended = event_valid & head_dat[9];
  assign fifo_count     = count_q;
  assign status_valid   = status_valid_q;
  assign status_code    = status_code_q;
  assign error_pulse    = error_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_ctl.sv
// Purpose: randomized + directed check of ps2_scancode_ctl against a sequence-level reference model.
// Latency: model is advanced once per clock, outputs compared on the falling edge.
// Backpressure: event_ready is driven both held-low (fill/overflow) and random (drain).
module tb_ps2_scancode_ctl;
  localparam int DEPTH = 8;
  localparam int TMO   = 16;
  localparam int INC = 0, EVT = 1, STA = 2, ERR = 3, DIS = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sync_reset = 1'b0;
  logic       enable_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       event_ready = 1'b0;
  logic       event_valid, event_extended, event_break;
  logic [7:0] event_code, status_code;
  logic       status_valid, error_pulse, overflow;
  logic [3:0] fifo_count;

  ps2_scancode_ctl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
    .enable_in(enable_in), .data_in(data_in),
    .event_valid(event_valid), .event_code(event_code),
    .event_extended(event_extended), .event_break(event_break),
    .event_ready(event_ready), .status_valid(status_valid),
    .status_code(status_code), .error_pulse(error_pulse),
    .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got_v, exp_v, $time);
    end
  endtask

  // Reference model: pending byte sequence, event queue, sticky/pulse outputs.
  logic [9:0] mq[$];
  logic [7:0] seq[$];
  logic [9:0] got[$];
  logic [9:0] exp_q[$];
  bit         m_stv, m_err, m_ovf;
  logic [7:0] m_stc;
  bit         chk_en = 1'b1;
  int         err_seen = 0;
  int         stv_seen = 0;

  function automatic bit is_stat(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  endfunction

  // Interprets a whole pending sequence: incomplete, key event, status, error or discard.
  function automatic int classify(input logic [7:0] s[$], output logic [9:0] ev);
    ev = '0;
    if (s[0] == 8'hE1) begin
      if (s.size() < 8) return INC;
      ev = {2'b10, 8'hE1};
      return EVT;
    end
    if (s.size() == 1) begin
      if (s[0] == 8'hE0 || s[0] == 8'hF0) return INC;
      if (is_stat(s[0])) return STA;
      ev = {2'b00, s[0]};
      return EVT;
    end
    if (s[0] == 8'hF0) begin
      if (s[1] inside {8'hE0, 8'hE1, 8'hF0}) return ERR;
      ev = {2'b01, s[1]};
      return EVT;
    end
    if (s.size() == 2) begin
      if (s[1] == 8'hF0) return INC;
      if (s[1] == 8'h12) return DIS;
      if (s[1] inside {8'hE0, 8'hE1}) return ERR;
      ev = {2'b10, s[1]};
      return EVT;
    end
    if (s[2] == 8'h12) return DIS;
    if (s[2] inside {8'hE0, 8'hE1, 8'hF0}) return ERR;
    ev = {2'b11, s[2]};
    return EVT;
  endfunction

  task automatic model_reset();
    mq.delete(); seq.delete();
    m_stv = 0; m_err = 0; m_ovf = 0; m_stc = 8'h00;
  endtask

  task automatic model_step(input bit en, input logic [7:0] d, input bit rdy, input bit srst);
    bit pop, push, full;
    int r;
    logic [9:0] ev;
    if (srst) begin
      model_reset();
      return;
    end
    m_stv = 0; m_err = 0;
    pop  = (mq.size() > 0) && rdy;
    push = 0;
    ev   = '0;
    if (en) begin
      seq.push_back(d);
      r = classify(seq, ev);
      if (r == EVT) push = 1;
      else if (r == STA) begin m_stv = 1; m_stc = d; end
      else if (r == ERR) m_err = 1;
      if (r != INC) seq.delete();
    end
    full = (mq.size() == DEPTH);
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (full && !pop) m_ovf = 1;
      else mq.push_back(ev);
    end
  endtask

  task automatic check_all();
    check("event_valid", event_valid, mq.size() > 0);
    check("event_head", {event_extended, event_break, event_code}, (mq.size() > 0) ? mq[0] : 10'h000);
    check("fifo_count", fifo_count, mq.size());
    check("status_valid", status_valid, m_stv);
    check("status_code", status_code, m_stc);
    check("error_pulse", error_pulse, m_err);
    check("overflow", overflow, m_ovf);
  endtask

  // One clock: inputs applied at the falling edge, outputs compared on the next falling edge.
  task automatic cyc(input bit en, input logic [7:0] d, input bit rdy, input bit srst);
    enable_in = en; data_in = d; event_ready = rdy; sync_reset = srst;
    #1;
    if (event_valid && rdy) got.push_back({event_extended, event_break, event_code});
    @(posedge clk);
    model_step(en, d, rdy, srst);
    @(negedge clk);
    enable_in = 1'b0; sync_reset = 1'b0;
    if (error_pulse)  err_seen++;
    if (status_valid) stv_seen++;
    if (chk_en) check_all();
  endtask

  task automatic send(input logic [7:0] d, input bit rdy);
    cyc(1'b1, d, rdy, 1'b0);
    cyc(1'b0, 8'h00, rdy, 1'b0);
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) cyc(1'b0, 8'h00, rdy, 1'b0);
  endtask

  task automatic want(input logic [9:0] v);
    exp_q.push_back(v);
  endtask

  task automatic expect_got(input string tag);
    check({tag, "_n"}, got.size(), exp_q.size());
    foreach (exp_q[i]) if (i < got.size()) check(tag, got[i], exp_q[i]);
    got.delete(); exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, event_valid, 0);
    check({tag, "_head"}, {event_extended, event_break, event_code}, 0);
    check({tag, "_count"}, fifo_count, 0);
    check({tag, "_stv"}, status_valid, 0);
    check({tag, "_stc"}, status_code, 0);
    check({tag, "_err"}, error_pulse, 0);
    check({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t2 [15] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h12, 8'hE0,
                            8'h7C, 8'hE0, 8'hF0, 8'h7C, 8'hE0, 8'hF0, 8'h12};
    logic [7:0] t3 [8]  = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    logic [7:0] stat_tbl [7] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
    int e0, s0;

    model_reset();
    #12;
    check_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Make then break of the same key.
    send(8'h1C, 0); send(8'hF0, 0); send(8'h1C, 0);
    check("t1_peak_count", fifo_count, 2);
    idle(4, 1);
    want(10'h01C); want(10'h11C);
    expect_got("t1_events");

    // Extended make/break with fake shifts discarded.
    foreach (t2[i]) send(t2[i], 0);
    idle(6, 1);
    want(10'h275); want(10'h375); want(10'h27C); want(10'h37C);
    expect_got("t2_events");

    // Pause sequence collapses to one event.
    e0 = err_seen;
    foreach (t3[i]) send(t3[i], 0);
    check("t3_count", fifo_count, 1);
    check("t3_no_error", err_seen - e0, 0);
    idle(3, 1);
    want(10'h2E1);
    expect_got("t3_events");

    // Overflow: ninth make code dropped, then drain one per cycle.
    for (int i = 1; i <= 9; i++) send(8'(i), 0);
    check("t4_full_count", fifo_count, 8);
    check("t4_overflow", overflow, 1);
    idle(8, 1);
    check("t4_drained", fifo_count, 0);
    for (int i = 1; i <= 8; i++) want({2'b00, 8'(i)});
    expect_got("t4_events");
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("t4_srst_ovf", overflow, 0);

    // Full FIFO with a pop in the same cycle as the push: nothing lost.
    for (int i = 1; i <= 8; i++) send(8'(i), 0);
    cyc(1'b1, 8'h09, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("t4b_count", fifo_count, 8);
    check("t4b_overflow", overflow, 0);
    idle(9, 1);
    for (int i = 1; i <= 9; i++) want({2'b00, 8'(i)});
    expect_got("t4b_events");

    // Timeout after a lone E0; following byte decodes as a plain make.
    send(8'hE0, 0);
    chk_en = 1'b0;
    e0 = err_seen;
    idle(40, 0);
    check("t5_timeout_once", err_seen - e0, 1);
    seq.delete();
    chk_en = 1'b1;
    send(8'h1C, 0);
    idle(3, 1);
    want(10'h01C);
    expect_got("t5_after_timeout");
    // A gap comfortably inside the limit keeps the sequence alive.
    e0 = err_seen;
    send(8'hE0, 0); idle(10, 0); send(8'h75, 0);
    check("t5_short_gap_err", err_seen - e0, 0);
    idle(3, 1);
    want(10'h275);
    expect_got("t5_short_gap");

    // Status byte, protocol error, async reset mid-sequence.
    s0 = stv_seen;
    send(8'hAA, 0);
    check("t6_status_once", stv_seen - s0, 1);
    check("t6_status_code", status_code, 8'hAA);
    check("t6_no_event", fifo_count, 0);
    e0 = err_seen;
    send(8'hF0, 0); send(8'hE0, 0);
    check("t6_f0e0_err", err_seen - e0, 1);
    send(8'h1C, 0); send(8'hE0, 0); send(8'hF0, 0);
    reset_n = 1'b0;
    #2;
    check_zero("t6_arst");
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    send(8'h1C, 0);
    idle(2, 1);
    want(10'h01C);
    expect_got("t6_after_arst");

    // Randomized byte stream against the model.
    begin
      bit rdy_mode;
      for (int n = 0; n < 400; n++) begin
        int r;
        logic [7:0] b;
        if (n % 25 == 0) rdy_mode = ($urandom_range(0, 2) != 0);
        r = $urandom_range(0, 99);
        if (r < 12)      b = 8'hE0;
        else if (r < 22) b = 8'hF0;
        else if (r < 26) b = 8'hE1;
        else if (r < 32) b = 8'h12;
        else if (r < 42) b = stat_tbl[$urandom_range(0, 6)];
        else             b = 8'($urandom_range(0, 255));
        cyc(1'b1, b, rdy_mode && ($urandom_range(0, 3) != 0), $urandom_range(0, 149) == 0);
        repeat ($urandom_range(0, 3)) cyc(1'b0, 8'h00, rdy_mode && ($urandom_range(0, 3) != 0), 1'b0);
      end
      got.delete();
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      check_zero("final_srst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
